hyper_mvblck_todram: RTL and testbench
======================================

# hyper_mvblck_todram

Moves one block of up to 31 words from a section of the LSAB read side (lsab_cr) into DRAM through the MCU collision port. It is the write-direction counterpart of the DRAM-to-LSAB block mover, driven by the same hyperfabric scheduler with the same issue interface. It clamps the request to what the LSAB section actually holds and pads unaligned blocks out to the MCU's even-aligned beat pairs. Pad beats are write-masked.

## Interface
- LEAD, 2: cycles between the LSAB_READ strobe for a word and that word's beat on the MCU port (LSAB read latency); legal 1..4.
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- START_ADDRESS  in  12  DRAM word address of first word.
- COUNT_REQ  in  5  words requested, 0..31.
- SECTION  in  2  LSAB section to drain.
- ISSUE  in  1  start request; sampled only in IDLE.
- LSAB_FILL  in  6  words currently held in each section's selected view (section = SECTION at issue).
- COUNT_SENT  out  5  words actually moved: min(COUNT_REQ, LSAB_FILL), registered at issue.
- WORKING  out  1  block busy.
- DONE  out  1  one-cycle pulse at completion.
- LSAB_READ  out  1  pop one word from LSAB_SECTION.
- LSAB_SECTION  out  2  section being read.
- MCU_COLL_ADDRESS  out  12  beat address.
- MCU_REQUEST_ACCESS  out  1  beat valid / bus held.
- MCU_WRITE_MASK  out  1  1 = suppress write on this beat.

## Operation
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE + ISSUE: latch n = min(COUNT_REQ, LSAB_FILL) into COUNT_SENT; latch LSAB_SECTION; odd = START_ADDRESS[0]; beats = (n + odd + 1) & ~1 (6-bit arithmetic, max 32); base = {START_ADDRESS[11:1],0}. n = 0 -> FINISH directly, no LSAB or MCU activity. Otherwise -> RUN.
- RUN: one beat per cycle, beat index b = 0..beats-1. Beat b is a pad if (odd && b==0) or b == n+odd. LSAB_READ = 1 only for non-pad beats. After the last beat -> DRAIN.
- The address/mask/valid of beat b are issued into a LEAD-deep delay line, so MCU sees address base+b, mask = pad, and REQUEST_ACCESS = 1 exactly LEAD cycles after beat b's RUN cycle.
- DRAIN: waits LEAD cycles until the delay line empties, then -> FINISH.
- FINISH: DONE = 1 for one cycle; WORKING = 0; -> IDLE.
- ISSUE outside IDLE is ignored (no queuing). Inputs other than ISSUE are only sampled on the issue cycle.
- Address wraps modulo 4096; there is no boundary check.

## Timing
- Reset values: WORKING 0, DONE 0, LSAB_READ 0, LSAB_SECTION 0, COUNT_SENT 0, MCU_COLL_ADDRESS 0, MCU_REQUEST_ACCESS 0, MCU_WRITE_MASK 0; state IDLE, delay line cleared.
- ISSUE sampled at edge T. RUN beats occupy cycles T+1 .. T+beats. WORKING is high from T+1 until FINISH.
- MCU beats occupy T+1+LEAD .. T+beats+LEAD. MCU_REQUEST_ACCESS is contiguous, with no gaps.
- FINISH (DONE pulse) is at cycle T+beats+LEAD+1.
- For n = 0: DONE at T+1, WORKING stays 0.
- Next ISSUE is accepted at the edge ending FINISH (earliest new RUN is T+beats+LEAD+2).
- Reset mid-operation: all outputs go to reset values asynchronously. Nothing completes, DONE is not asserted, and partial DRAM writes are not rolled back.

## Structure
- Package hyper_mvblck_pkg holds: the state enum (IDLE, RUN, DRAIN, FINISH); DRAM address width 12; count width 5; section width 2; the beat-count formula as a function, shared with the DRAM-to-LSAB mover.
- One sub-module, hyper_mvblck_delay: a LEAD-stage shift register carrying {valid, mask, address}, with asynchronous clear.

## Test plan
- START 0x010, COUNT_REQ 4, FILL 10, ISSUE at T:
  - COUNT_SENT 4; LSAB_READ at T+1..T+4.
  - MCU addresses 0x010..0x013 at T+3..T+6, mask 0.
  - DONE at T+7.
- START 0x011, COUNT_REQ 4, FILL 10:
  - 6 beats at 0x010..0x015; mask on 0x010 and 0x015 only.
  - LSAB_READ at T+2..T+5; DONE at T+9.
- START 0x011, COUNT_REQ 3: 4 beats at 0x010..0x013; mask on 0x010 only; three LSAB_READs.
- COUNT_REQ 20, FILL 7, START 0x000: COUNT_SENT 7; 8 beats; last beat 0x007 masked; exactly 7 LSAB_READs.
- FILL 0 (or COUNT_REQ 0): COUNT_SENT 0; DONE at T+1; no LSAB_READ and no MCU_REQUEST_ACCESS; WORKING never 1.
- Busy and reset cases:
  - ISSUE pulsed during RUN: ignored, COUNT_SENT unchanged.
  - RST low mid-RUN: all outputs 0 immediately; a fresh ISSUE after reset release behaves as in the first scenario.

Source files
------------

// File: rtl/hyper_mvblck_pkg.sv
// Shared types and helpers for the hyperfabric block movers (LSAB <-> DRAM).
package hyper_mvblck_pkg;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 5;
  localparam int SEC_W  = 2;
  localparam int FILL_W = 6;
  localparam int BEAT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_e;

  // MCU beats come in even-aligned pairs; an odd start adds a leading pad.
  function automatic logic [BEAT_W-1:0] beat_count(input logic [CNT_W-1:0] n,
                                                   input logic odd);
    logic [BEAT_W-1:0] sum;
    sum = BEAT_W'(n) + BEAT_W'(odd) + BEAT_W'(1);
    return sum & ~BEAT_W'(1);
  endfunction

  function automatic logic is_pad(input logic [BEAT_W-1:0] b,
                                  input logic [CNT_W-1:0] n,
                                  input logic odd);
    return (odd && (b == '0)) || (b == (BEAT_W'(n) + BEAT_W'(odd)));
  endfunction

endpackage

// File: rtl/hyper_mvblck_delay.sv
// LEAD-stage shift register aligning beat {valid, mask, address} with LSAB read data.
module hyper_mvblck_delay #(
  parameter int LEAD = 2,
  parameter int W    = 14
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [LEAD];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LEAD; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < LEAD; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[LEAD-1];

endmodule

// File: rtl/hyper_mvblck_todram.sv
// Block mover: drains up to 31 words from an LSAB section into DRAM via the MCU
// collision port, padding unaligned blocks with write-masked beats.
module hyper_mvblck_todram
  import hyper_mvblck_pkg::*;
#(
  parameter int LEAD = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] start_address_i,
  input  logic [CNT_W-1:0]  count_req_i,
  input  logic [SEC_W-1:0]  section_i,
  input  logic              issue_i,
  input  logic [FILL_W-1:0] lsab_fill_i,
  output logic [CNT_W-1:0]  count_sent_o,
  output logic              working_o,
  output logic              done_o,
  output logic              lsab_read_o,
  output logic [SEC_W-1:0]  lsab_section_o,
  output logic [ADDR_W-1:0] mcu_coll_address_o,
  output logic              mcu_request_access_o,
  output logic              mcu_write_mask_o
);

  localparam logic [1:0] DRAIN_INIT = 2'(LEAD - 1);
  localparam int         DLY_W      = ADDR_W + 2;

  state_e              state_q;
  logic [CNT_W-1:0]    n_q;
  logic                odd_q;
  logic [BEAT_W-1:0]   beats_q;
  logic [BEAT_W-1:0]   b_q;
  logic [ADDR_W-1:0]   base_q;
  logic [1:0]          drain_q;
  logic [CNT_W-1:0]    count_sent_q;
  logic                working_q;
  logic                done_q;
  logic                lsab_read_q;
  logic [SEC_W-1:0]    section_q;
  logic                beat_valid_q;
  logic                beat_mask_q;
  logic [ADDR_W-1:0]   beat_addr_q;

  logic [CNT_W-1:0]    n_d;
  logic                odd_d;
  logic [BEAT_W-1:0]   beats_d;
  logic [ADDR_W-1:0]   base_d;
  logic                pad0_d;
  logic                pad_run_d;
  logic [DLY_W-1:0]    dly_out;

  // Request is clamped to what the section actually holds.
  assign n_d       = (lsab_fill_i < FILL_W'(count_req_i)) ? lsab_fill_i[CNT_W-1:0] : count_req_i;
  assign odd_d     = start_address_i[0];
  assign beats_d   = beat_count(n_d, odd_d);
  assign base_d    = {start_address_i[ADDR_W-1:1], 1'b0};
  assign pad0_d    = is_pad('0, n_d, odd_d);
  assign pad_run_d = is_pad(b_q, n_q, odd_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      n_q          <= '0;
      odd_q        <= 1'b0;
      beats_q      <= '0;
      b_q          <= '0;
      base_q       <= '0;
      drain_q      <= '0;
      count_sent_q <= '0;
      working_q    <= 1'b0;
      done_q       <= 1'b0;
      lsab_read_q  <= 1'b0;
      section_q    <= '0;
      beat_valid_q <= 1'b0;
      beat_mask_q  <= 1'b0;
      beat_addr_q  <= '0;
    end else begin
      done_q       <= 1'b0;
      lsab_read_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_mask_q  <= 1'b0;
      beat_addr_q  <= '0;
      case (state_q)
        IDLE, FINISH: begin
          if (issue_i) begin
            count_sent_q <= n_d;
            section_q    <= section_i;
            n_q          <= n_d;
            odd_q        <= odd_d;
            beats_q      <= beats_d;
            base_q       <= base_d;
            if (n_d == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              // Beat 0 goes out on the issue edge so RUN spans exactly 'beats' cycles.
              state_q      <= RUN;
              working_q    <= 1'b1;
              beat_valid_q <= 1'b1;
              beat_mask_q  <= pad0_d;
              beat_addr_q  <= base_d;
              lsab_read_q  <= !pad0_d;
              b_q          <= BEAT_W'(1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (b_q < beats_q) begin
            beat_valid_q <= 1'b1;
            beat_mask_q  <= pad_run_d;
            beat_addr_q  <= base_q + ADDR_W'(b_q);
            lsab_read_q  <= !pad_run_d;
            b_q          <= b_q + BEAT_W'(1);
          end else begin
            state_q <= DRAIN;
            drain_q <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q   <= FINISH;
            done_q    <= 1'b1;
            working_q <= 1'b0;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hyper_mvblck_delay #(
    .LEAD (LEAD),
    .W    (DLY_W)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({beat_valid_q, beat_mask_q, beat_addr_q}),
    .q_o    (dly_out)
  );

  assign count_sent_o         = count_sent_q;
  assign working_o            = working_q;
  assign done_o               = done_q;
  assign lsab_read_o          = lsab_read_q;
  assign lsab_section_o       = section_q;
  assign mcu_request_access_o = dly_out[DLY_W-1];
  assign mcu_write_mask_o     = dly_out[DLY_W-2];
  assign mcu_coll_address_o   = dly_out[ADDR_W-1:0];

endmodule

// File: tb/tb_hyper_mvblck_todram.sv
// Directed bench for hyper_mvblck_todram: MCU beats checked against a scoreboard,
// per-block timing checked against cycle numbers derived from the issue edge.
module tb_hyper_mvblck_todram;

  localparam int LEAD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] start_address = '0;
  logic [4:0]  count_req = '0;
  logic [1:0]  section = '0;
  logic        issue = 1'b0;
  logic [5:0]  lsab_fill = '0;
  logic [4:0]  count_sent;
  logic        working, done, lsab_read;
  logic [1:0]  lsab_section;
  logic [11:0] mcu_addr;
  logic        mcu_req, mcu_mask;

  hyper_mvblck_todram #(.LEAD(LEAD)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .start_address_i      (start_address),
    .count_req_i          (count_req),
    .section_i            (section),
    .issue_i              (issue),
    .lsab_fill_i          (lsab_fill),
    .count_sent_o         (count_sent),
    .working_o            (working),
    .done_o               (done),
    .lsab_read_o          (lsab_read),
    .lsab_section_o       (lsab_section),
    .mcu_coll_address_o   (mcu_addr),
    .mcu_request_access_o (mcu_req),
    .mcu_write_mask_o     (mcu_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] addr;
    logic        mask;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_b;
  logic [1:0] exp_sec;
  int total = 0, bad = 0;
  int rd_cnt, rd_first, rd_last, mcu_cnt, mcu_first, mcu_last, wk_cnt, done_cnt, done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; rd_first = -1; rd_last = -1;
    mcu_cnt = 0; mcu_first = -1; mcu_last = -1;
    wk_cnt = 0; done_cnt = 0; done_cyc = -1;
  endtask

  // Monitor: gathers timing stats and pops the scoreboard on every MCU beat.
  always @(negedge clk) begin
    if (lsab_read) begin
      if (rd_cnt == 0) rd_first = cyc;
      rd_last = cyc;
      rd_cnt++;
      check("lsab_section", 32'(lsab_section), 32'(exp_sec));
    end
    if (working) wk_cnt++;
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (mcu_req) begin
      if (mcu_cnt == 0) mcu_first = cyc;
      mcu_last = cyc;
      mcu_cnt++;
      if (exp_q.size() == 0) begin
        check("mcu_unexpected_beat", 32'(mcu_addr), 32'hFFFF_FFFF);
      end else begin
        mon_b = exp_q.pop_front();
        check("mcu_addr", 32'(mcu_addr), 32'(mon_b.addr));
        check("mcu_mask", 32'(mcu_mask), 32'(mon_b.mask));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check(tag, 32'({working, done, lsab_read, lsab_section, count_sent,
                    mcu_addr, mcu_req, mcu_mask}), 32'd0);
  endtask

  // mode 0: plain block, 1: ISSUE poked during RUN, 2: reset asserted mid-RUN
  task automatic run(input logic [11:0] start, input logic [4:0] req, input logic [5:0] fill,
                     input logic [1:0] sec, input int mode);
    int n, odd, beats, t0;
    logic [11:0] base;
    n     = (int'(fill) < int'(req)) ? int'(fill) : int'(req);
    odd   = int'(start[0]);
    beats = (n == 0) ? 0 : ((n + odd + 1) & ~1);
    base  = {start[11:1], 1'b0};
    clear_stats();
    exp_sec = sec;
    for (int b = 0; b < beats; b++)
      exp_q.push_back(beat_t'{addr: 12'(int'(base) + b),
                              mask: (odd == 1 && b == 0) || (b == n + odd)});

    @(negedge clk);
    start_address = start; count_req = req; lsab_fill = fill; section = sec; issue = 1'b1;
    t0 = cyc;
    @(negedge clk);
    issue = 1'b0;
    // Scramble non-issue inputs: they must only matter on the issue edge.
    start_address = 12'($urandom); count_req = 5'($urandom);
    lsab_fill = 6'($urandom); section = 2'($urandom);
    check("count_sent", 32'(count_sent), 32'(n));

    if (mode == 2) begin
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("reset_async_outputs");
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_held_outputs");
      check("reset_no_done", 32'(done_cnt), 32'd0);
      rst_n = 1'b1;
      return;
    end

    if (mode == 1) begin
      @(negedge clk);
      issue = 1'b1; count_req = 5'd3; lsab_fill = 6'd63; start_address = 12'h555;
      @(negedge clk);
      issue = 1'b0;
      check("count_sent_busy", 32'(count_sent), 32'(n));
    end

    for (int k = 0; k < 200 && done_cnt == 0; k++) @(negedge clk);
    repeat (LEAD + 3) @(negedge clk);

    check("done_cycle", 32'(done_cyc - t0), 32'((n == 0) ? 1 : beats + LEAD + 1));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("lsab_reads", 32'(rd_cnt), 32'(n));
    check("mcu_beats", 32'(mcu_cnt), 32'(beats));
    check("working_cycles", 32'(wk_cnt), 32'((n == 0) ? 0 : beats + LEAD));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    if (n > 0) begin
      check("read_first", 32'(rd_first - t0), 32'(1 + odd));
      check("read_last", 32'(rd_last - t0), 32'(odd + n));
      check("mcu_first", 32'(mcu_first - t0), 32'(1 + LEAD));
      check("mcu_last", 32'(mcu_last - t0), 32'(beats + LEAD));
      check("mcu_contiguous", 32'(mcu_last - mcu_first + 1), 32'(mcu_cnt));
    end
  endtask

  initial begin
    clear_stats();
    exp_sec = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    run(12'h010, 5'd4,  6'd10, 2'd1, 0);  // aligned
    run(12'h011, 5'd4,  6'd10, 2'd2, 0);  // odd start, leading and trailing pad
    run(12'h011, 5'd3,  6'd10, 2'd3, 0);  // odd start, odd count
    run(12'h000, 5'd20, 6'd7,  2'd0, 0);  // clamped by fill
    run(12'h020, 5'd5,  6'd0,  2'd1, 0);  // empty section
    run(12'h020, 5'd0,  6'd10, 2'd2, 0);  // zero request
    run(12'hFFF, 5'd31, 6'd40, 2'd3, 0);  // max block, address wrap
    run(12'h100, 5'd10, 6'd20, 2'd1, 1);  // ISSUE during RUN ignored
    run(12'h010, 5'd4,  6'd10, 2'd1, 2);  // reset mid-RUN
    run(12'h010, 5'd4,  6'd10, 2'd1, 0);  // fresh block after reset

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
